// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit add/subtract-with-carry unit whose carry chain
// is cut into STAGES equal slices, one register stage per slice. Each stage
// adds its own slice using the carry registered by the stage before it. The
// consumed result slices, the unconsumed operand slices, the valid bit and
// the operand sign bits travel with the operation. The final stage produces
// sum, carry-out, signed overflow and zero. All outputs are zeroed for an
// invalid slot. A global stall freezes every register, outputs included.
module pipelined_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             stall,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int CHUNK = WIDTH / STAGES;
    // Number of inter-stage registers; with a single stage there are none,
    // and one dummy entry (held at reset value) keeps the arrays non-empty.
    localparam int NPIPE = (STAGES > 1) ? (STAGES - 1) : 1;

    // Bits at or above position lo are kept. This drops the operand slices
    // that a stage has already consumed, so only live bits are carried on.
    function automatic logic [WIDTH-1:0] upper_mask(input int lo);
        logic [WIDTH-1:0] m;
        for (int i = 0; i < WIDTH; i++) begin
            m[i] = (i >= lo) ? 1'b1 : 1'b0;
        end
        return m;
    endfunction

    // Effective operands: subtract is a + ~b + ~cin.
    logic [WIDTH-1:0] b_eff_s;
    logic             c0_s;

    // Per-stage inputs, seen by the slice adder of stage k.
    logic [WIDTH-1:0] st_a_s   [STAGES];
    logic [WIDTH-1:0] st_b_s   [STAGES];
    logic [WIDTH-1:0] st_res_s [STAGES];
    logic             st_c_s   [STAGES];
    logic             st_v_s   [STAGES];
    logic             st_am_s  [STAGES];
    logic             st_bm_s  [STAGES];

    // Per-stage results, loaded into the next stage's registers.
    logic [CHUNK:0]   slice_s  [STAGES];
    logic [WIDTH-1:0] nx_res_s [STAGES];
    logic [WIDTH-1:0] nx_a_s   [STAGES];
    logic [WIDTH-1:0] nx_b_s   [STAGES];
    logic [CHUNK-1:0] sl_a_s;
    logic [CHUNK-1:0] sl_b_s;
    int               prev_s;

    // Inter-stage registers: entry k holds the state leaving stage k.
    logic [WIDTH-1:0] pipe_a_r   [NPIPE];
    logic [WIDTH-1:0] pipe_b_r   [NPIPE];
    logic [WIDTH-1:0] pipe_res_r [NPIPE];
    logic             pipe_c_r   [NPIPE];
    logic             pipe_v_r   [NPIPE];
    logic             pipe_am_r  [NPIPE];
    logic             pipe_bm_r  [NPIPE];

    // Final-stage values, registered onto the outputs.
    logic [WIDTH-1:0] fin_sum_s;
    logic             fin_v_s;
    logic             fin_cout_s;
    logic             fin_ovf_s;
    logic             fin_zero_s;

    // Form the effective operands and carry-in for the add/subtract mode.
    always_comb begin
        b_eff_s = {WIDTH{1'b0}};
        c0_s    = 1'b0;
        if (sub) begin
            b_eff_s = ~b;
            c0_s    = ~cin;
        end else begin
            b_eff_s = b;
            c0_s    = cin;
        end
    end

    // Slice adders: route each stage's inputs and compute its slice.
    always_comb begin
        sl_a_s = {CHUNK{1'b0}};
        sl_b_s = {CHUNK{1'b0}};
        prev_s = 0;
        for (int k = 0; k < STAGES; k++) begin
            if (k == 0) begin
                // A bubble enters as all-zero data with valid low.
                st_a_s[k]   = in_valid ? a : {WIDTH{1'b0}};
                st_b_s[k]   = in_valid ? b_eff_s : {WIDTH{1'b0}};
                st_res_s[k] = {WIDTH{1'b0}};
                st_c_s[k]   = in_valid & c0_s;
                st_v_s[k]   = in_valid;
                st_am_s[k]  = in_valid & a[WIDTH-1];
                st_bm_s[k]  = in_valid & b_eff_s[WIDTH-1];
            end else begin
                prev_s      = (k > 0) ? (k - 1) : 0;
                st_a_s[k]   = pipe_a_r[prev_s];
                st_b_s[k]   = pipe_b_r[prev_s];
                st_res_s[k] = pipe_res_r[prev_s];
                st_c_s[k]   = pipe_c_r[prev_s];
                st_v_s[k]   = pipe_v_r[prev_s];
                st_am_s[k]  = pipe_am_r[prev_s];
                st_bm_s[k]  = pipe_bm_r[prev_s];
            end
            sl_a_s      = CHUNK'(st_a_s[k] >> (k * CHUNK));
            sl_b_s      = CHUNK'(st_b_s[k] >> (k * CHUNK));
            slice_s[k]  = {1'b0, sl_a_s} + {1'b0, sl_b_s} + {{CHUNK{1'b0}}, st_c_s[k]};
            nx_res_s[k] = st_res_s[k] | (WIDTH'(slice_s[k][CHUNK-1:0]) << (k * CHUNK));
            nx_a_s[k]   = st_a_s[k] & upper_mask((k + 1) * CHUNK);
            nx_b_s[k]   = st_b_s[k] & upper_mask((k + 1) * CHUNK);
        end
    end

    // Final-stage flags, each qualified by the stage's valid bit.
    always_comb begin
        fin_sum_s  = {WIDTH{1'b0}};
        fin_v_s    = st_v_s[STAGES-1];
        fin_cout_s = 1'b0;
        fin_ovf_s  = 1'b0;
        fin_zero_s = 1'b0;
        if (fin_v_s) begin
            fin_sum_s  = nx_res_s[STAGES-1];
            fin_cout_s = slice_s[STAGES-1][CHUNK];
            fin_ovf_s  = (st_am_s[STAGES-1] == st_bm_s[STAGES-1]) &&
                         (nx_res_s[STAGES-1][WIDTH-1] != st_am_s[STAGES-1]);
            fin_zero_s = (nx_res_s[STAGES-1] == {WIDTH{1'b0}});
        end else begin
            fin_sum_s  = {WIDTH{1'b0}};
            fin_cout_s = 1'b0;
            fin_ovf_s  = 1'b0;
            fin_zero_s = 1'b0;
        end
    end

    // Inter-stage registers advance together unless stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NPIPE; k++) begin
                pipe_a_r[k]   <= {WIDTH{1'b0}};
                pipe_b_r[k]   <= {WIDTH{1'b0}};
                pipe_res_r[k] <= {WIDTH{1'b0}};
                pipe_c_r[k]   <= 1'b0;
                pipe_v_r[k]   <= 1'b0;
                pipe_am_r[k]  <= 1'b0;
                pipe_bm_r[k]  <= 1'b0;
            end
        end else if (!stall) begin
            for (int k = 0; k < STAGES - 1; k++) begin
                pipe_a_r[k]   <= nx_a_s[k];
                pipe_b_r[k]   <= nx_b_s[k];
                pipe_res_r[k] <= nx_res_s[k];
                pipe_c_r[k]   <= slice_s[k][CHUNK];
                pipe_v_r[k]   <= st_v_s[k];
                pipe_am_r[k]  <= st_am_s[k];
                pipe_bm_r[k]  <= st_bm_s[k];
            end
        end
    end

    // Output registers: the last stage writes result and flags directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            sum       <= {WIDTH{1'b0}};
            cout      <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
        end else if (!stall) begin
            out_valid <= fin_v_s;
            sum       <= fin_sum_s;
            cout      <= fin_cout_s;
            ovf       <= fin_ovf_s;
            zero      <= fin_zero_s;
        end
    end

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: three configurations (32/4, 8/1, 16/16) share
// one stimulus stream. An integer-arithmetic model predicts every accepted
// operation into a per-instance queue; a negedge monitor matches results in
// order, checks zeroed idle slots, held outputs under stall and reset zeros.
module tb_pipelined_adder;

    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        stall = 1'b0;
    logic        sub = 1'b0;
    logic        cin = 1'b0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;

    logic        v32, co32, of32, z32;
    logic [31:0] s32;
    logic        v8, co8, of8, z8;
    logic [7:0]  s8;
    logic        v16, co16, of16, z16;
    logic [15:0] s16;

    int          n_checks = 0;
    int          n_fail = 0;
    int          wid [3] = '{32, 8, 16};
    int          stg [3] = '{4, 1, 16};
    exp_t        q [3][$];
    logic        adv = 1'b0;
    logic [35:0] last [3] = '{36'd0, 36'd0, 36'd0};
    int          nvalid [3] = '{0, 0, 0};
    int          holes [3] = '{0, 0, 0};
    int          holes_final [3] = '{0, 0, 0};
    bit          seen [3] = '{1'b0, 1'b0, 1'b0};

    pipelined_adder #(.WIDTH(32), .STAGES(4)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall), .sub(sub),
        .a(a), .b(b), .cin(cin), .out_valid(v32), .sum(s32), .cout(co32),
        .ovf(of32), .zero(z32));

    pipelined_adder #(.WIDTH(8), .STAGES(1)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall), .sub(sub),
        .a(a[7:0]), .b(b[7:0]), .cin(cin), .out_valid(v8), .sum(s8), .cout(co8),
        .ovf(of8), .zero(z8));

    pipelined_adder #(.WIDTH(16), .STAGES(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall), .sub(sub),
        .a(a[15:0]), .b(b[15:0]), .cin(cin), .out_valid(v16), .sum(s16), .cout(co16),
        .ovf(of16), .zero(z16));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] req);
        n_checks++;
        if (obs !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", tag, obs, req);
        end
    endtask

    // Plain integer arithmetic: a +/- b +/- cin on w-bit values.
    function automatic exp_t model(input int w, input logic [31:0] aa, input logic [31:0] bb,
                                   input logic c, input logic s);
        longint m, ua, ub, full, half, sa, sb, sr, ci;
        exp_t e;
        m    = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        ua   = longint'({32'd0, aa}) & m;
        ub   = longint'({32'd0, bb}) & m;
        ci   = c ? 1 : 0;
        sa   = (ua >= half) ? ua - 2 * half : ua;
        sb   = (ub >= half) ? ub - 2 * half : ub;
        if (s) begin
            full   = ua - ub - ci;
            e.cout = (ua >= ub + ci);
            sr     = sa - sb - ci;
        end else begin
            full   = ua + ub + ci;
            e.cout = (full > m);
            sr     = sa + sb + ci;
        end
        e.sum  = 32'(full & m);
        e.ovf  = (sr < -half) || (sr >= half);
        e.zero = (e.sum == 32'd0);
        return e;
    endfunction

    function automatic logic [35:0] outs(input int i);
        case (i)
            0:       return {v32, co32, of32, z32, s32};
            1:       return {v8, co8, of8, z8, 24'd0, s8};
            default: return {v16, co16, of16, z16, 16'd0, s16};
        endcase
    endfunction

    // Reference model: record each accepted operation, discard on reset.
    always @(posedge clk) begin
        adv <= !stall;
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) q[i].delete();
        end else if (in_valid && !stall) begin
            for (int i = 0; i < 3; i++) q[i].push_back(model(wid[i], a, b, cin, sub));
        end
    end

    // Monitor: compare every output slot of every instance.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            logic [35:0] cur;
            exp_t e;
            cur = outs(i);
            if (!rst_n) begin
                chk($sformatf("reset_zero_i%0d", i), 64'(cur), 64'd0);
            end else if (!adv) begin
                chk($sformatf("stall_hold_i%0d", i), 64'(cur), 64'(last[i]));
            end else if (cur[35]) begin
                nvalid[i]++;
                seen[i] = 1'b1;
                holes_final[i] = holes[i];
                if (q[i].size() == 0) begin
                    chk($sformatf("unexpected_valid_i%0d", i), 64'd1, 64'd0);
                end else begin
                    e = q[i].pop_front();
                    chk($sformatf("result_i%0d", i), 64'(cur),
                        64'({1'b1, e.cout, e.ovf, e.zero, e.sum}));
                end
            end else begin
                if (seen[i]) holes[i]++;
                chk($sformatf("idle_zero_i%0d", i), 64'(cur), 64'd0);
            end
            last[i] = cur;
        end
    end

    // One isolated operation: check latency and single-cycle out_valid.
    task automatic run_one(input logic [31:0] aa, input logic [31:0] bb,
                           input logic c, input logic s);
        int first [3];
        int cnt [3];
        a = aa; b = bb; cin = c; sub = s; in_valid = 1'b1; stall = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin first[i] = 0; cnt[i] = 0; end
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                logic [35:0] o;
                o = outs(i);
                if (o[35]) begin
                    if (first[i] == 0) first[i] = cyc;
                    cnt[i]++;
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("latency_i%0d", i), 64'(first[i]), 64'(stg[i]));
            chk($sformatf("valid_once_i%0d", i), 64'(cnt[i]), 64'd1);
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0; stall = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        int kinds [12] = '{0, 0, 0, 0, 1, 0, 0, 2, 2, 2, 0, 0};

        // Reset held with random activity on the inputs.
        repeat (5) begin
            in_valid = 1'($urandom); stall = 1'($urandom); sub = 1'($urandom);
            cin = 1'($urandom); a = $urandom; b = $urandom;
            @(posedge clk); #1;
        end
        rst_n = 1'b1;
        idle(2);

        // Directed add/sub corner cases.
        run_one(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
        run_one(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0);
        run_one(32'h8000_0000, 32'd1, 1'b0, 1'b1);
        run_one(32'd5, 32'd7, 1'b0, 1'b1);
        run_one(32'd7, 32'd5, 1'b1, 1'b1);
        run_one(32'd0, 32'd0, 1'b0, 1'b1);
        run_one(32'h0000_007F, 32'h0000_7FFF, 1'b1, 1'b0);

        // Stream: 8 ops, one bubble, 3-cycle stall.
        for (int i = 0; i < 3; i++) begin
            nvalid[i] = 0; holes[i] = 0; holes_final[i] = 0; seen[i] = 1'b0;
        end
        for (int k = 0; k < 12; k++) begin
            a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
            in_valid = (kinds[k] != 1);
            stall = (kinds[k] == 2);
            @(posedge clk); #1;
        end
        idle(25);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("stream_count_i%0d", i), 64'(nvalid[i]), 64'd8);
            chk($sformatf("stream_bubble_i%0d", i), 64'(holes_final[i]), 64'd1);
        end

        // Reset with operations in flight.
        for (int k = 0; k < 5; k++) begin
            a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("pre_reset_valid", 64'(v32), 64'd1);
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) chk($sformatf("async_reset_i%0d", i), 64'(outs(i)), 64'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        idle(20);
        run_one(32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0);

        // Random soak with random stalls and bubbles.
        for (int k = 0; k < 400; k++) begin
            case ($urandom_range(0, 3))
                0:       a = 32'hFFFF_FFFF;
                1:       a = 32'h8000_0000;
                default: a = $urandom;
            endcase
            b = ($urandom_range(0, 4) == 0) ? a : $urandom;
            cin = 1'($urandom); sub = 1'($urandom);
            in_valid = ($urandom_range(0, 9) < 7);
            stall = ($urandom_range(0, 9) < 2);
            @(posedge clk); #1;
        end
        idle(25);
        for (int i = 0; i < 3; i++) chk($sformatf("drained_i%0d", i), 64'(q[i].size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipelined_adder.md
# pipelined_adder

Parametrised, pipelined add/subtract unit for the MIPS datapath ALU and address-generation paths. It generalises the single-bit combinational full-adder cell to a WIDTH-bit adder with add/subtract-with-carry mode. The carry chain is split into STAGES equal slices, one register stage per slice, so the unit meets timing at higher clock rates. A valid bit travels with each operation, a global stall freezes the pipeline, and carry, signed-overflow and zero flags are produced alongside the sum.

## Interface
- WIDTH, 32, operand/result width in bits; must be ≥ 1.
- STAGES, 4, number of pipeline stages and carry slices; 1 ≤ STAGES ≤ WIDTH and WIDTH % STAGES == 0. Slice width is CHUNK = WIDTH/STAGES.

- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operation present on a, b, cin, sub this cycle.
- stall  input  1  freezes every pipeline register; in_valid is ignored while high.
- sub  input  1  0 = add, 1 = subtract.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in when adding, borrow-in when subtracting.
- out_valid  output  1  result outputs carry a completed operation.
- sum  output  WIDTH  result.
- cout  output  1  carry-out; when subtracting, 1 means no borrow.
- ovf  output  1  two's-complement signed overflow.
- zero  output  1  result equals zero.

## Operation
- Effective operands: b_eff = sub ? ~b : b, and c0 = sub ? ~cin : cin.
- Add computes a + b + cin. Subtract computes a − b − cin = a + ~b + ~cin.
- Stage k (k = 1..STAGES) computes bits [k·CHUNK−1 : (k−1)·CHUNK] using the carry registered by stage k−1. Stage 1 uses c0.
- Stage k registers:
  - its sum slice,
  - the carry out of its slice,
  - all lower result slices already computed,
  - all still-unconsumed upper operand slices,
  - the valid bit,
  - the MSB of a and of b_eff.
- Final stage:
  - cout = carry out of bit WIDTH−1.
  - ovf = (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB]).
  - zero = (sum == 0).
- Flag qualification: sum, cout, ovf and zero are all forced to 0 whenever the stage's valid bit is 0.
- Bubbles: when in_valid = 0 and stall = 0, stage 1 loads valid = 0 and all-zero data. The bubble propagates like any other entry.
- Stall: while stall = 1, every register holds, including the valid bits and the outputs. An input presented while stall = 1 is not accepted. Results are never dropped, duplicated or reordered.
- Reset: asserting rst_n = 0 immediately (asynchronously) clears every stage. All outputs become 0, including out_valid.
- Reset mid-operation: in-flight operations are discarded. The first out_valid after release belongs to an operation accepted after release.
- STAGES = 1: the unit is a single registered WIDTH-bit adder.

## Timing
- Acceptance: an operation is accepted at rising edge N when in_valid = 1 and stall = 0.
- Latency: the result is visible on the outputs after edge N+STAGES−1, i.e. STAGES cycles from presentation. Each stalled edge adds one cycle.
- Throughput: one operation per cycle with no stall. Back-to-back operations produce back-to-back out_valid.
- All outputs are registered; there is no combinational path from any input to any output.
- Reset values: out_valid = 0, sum = 0, cout = 0, ovf = 0, zero = 0.
- Simultaneous stall and in_valid: stall wins and the input is not accepted.
- Simultaneous rst_n low and any other input: reset wins.

## Test plan
- Reset:
  - Stimulus: hold rst_n = 0 with random inputs, then release.
  - Required: all outputs 0 throughout reset; out_valid stays 0 until STAGES cycles after the first accepted operation.
- Wrap-around (WIDTH=32, STAGES=4):
  - Stimulus: a=32'hFFFF_FFFF, b=1, cin=0, sub=0.
  - Required: 4 cycles later sum=0, cout=1, zero=1, ovf=0, out_valid=1 for exactly one cycle.
- Signed overflow:
  - Stimulus A: a=32'h7FFF_FFFF + b=1. Required: sum=32'h8000_0000, ovf=1, cout=0.
  - Stimulus B: 32'h8000_0000 − 1 with cin=0. Required: sum=32'h7FFF_FFFF, ovf=1, cout=1.
- Subtract with borrow:
  - 5 − 7, cin=0. Required: sum=32'hFFFF_FFFE, cout=0, ovf=0.
  - 7 − 5, cin=1. Required: sum=1, cout=1.
  - 0 − 0, cin=0. Required: zero=1, cout=1.
- Streaming with stall and bubble:
  - Stimulus: 8 random back-to-back ops with one in_valid=0 gap, and stall high for 3 cycles mid-stream.
  - Required: 8 results in order matching the reference model; outputs frozen during stall; exactly one invalid slot for the bubble.
- Reset mid-stream and alternate parameters:
  - Stimulus: drop rst_n while 3 ops are in flight.
  - Required: outputs 0 immediately; none of those ops emerge after release.
  - Also rerun the add/sub checks with WIDTH=8, STAGES=1 and WIDTH=16, STAGES=16.
